// File: rtl/gb_rom_loader.sv
// rtl/gb_rom_loader.sv - HPS ROM download sequencer for the Green Beret core
// Queues download bytes, routes them to CPU/CHR/sprite/PROM writes and holds the core in reset.
module gb_rom_loader #(
   parameter logic [24:0] CHR_BASE   = 25'h0C000,
   parameter logic [24:0] SPR_BASE   = 25'h10000,
   parameter logic [24:0] PROM_BASE  = 25'h18000,
   parameter logic [24:0] ROM_END    = 25'h18220,
   parameter int          FIFO_DEPTH = 4,
   parameter int          HOLD_CYC   = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [24:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic [7:0]  wr_data,
   output logic        cpu_we,
   output logic [15:0] cpu_addr,
   output logic        chr_we,
   output logic [13:0] chr_addr,
   output logic        spr_req,
   input  logic        spr_ack,
   output logic [13:0] spr_addr,
   output logic [15:0] spr_data,
   output logic        prom_we,
   output logic [9:0]  prom_addr,
   output logic        core_reset,
   output logic        load_done,
   output logic        err_ovf
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(HOLD_CYC + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, SPR_WAIT} state_t;
   state_t state, state_n;

   logic [32:0]   fifo_mem [FIFO_DEPTH];
   logic [PW:0]   wr_ptr, rd_ptr;
   logic          fifo_empty, fifo_full, push, pop;
   logic [24:0]   head_addr;
   logic [7:0]    head_data;
   logic [14:0]   spr_off;
   logic [7:0]    spr_low;
   logic          pend_valid;
   logic [13:0]   pend_waddr;
   logic [7:0]    pend_byte;
   logic          dl_active_d, dl_rise, dl_seen, busy;
   logic [HW-1:0] hold_cnt;

   // Full is judged before any same-cycle pop, so a pop never makes room for a byte arriving with it.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign push       = dl_wr && !fifo_full;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign {head_addr, head_data} = fifo_mem[rd_ptr[PW-1:0]];
   assign spr_off    = 15'(head_addr - SPR_BASE);
   assign spr_low    = (pend_valid && pend_waddr == spr_off[14:1]) ? pend_byte : 8'h00;
   assign dl_rise    = dl_active && !dl_active_d;
   assign busy       = dl_active || !fifo_empty || (state != IDLE);
   assign core_reset = reset || busy || dl_seen;

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {dl_addr, dl_data};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (!fifo_empty) state_n = ISSUE;
         ISSUE:    state_n = (spr_req && !spr_ack) ? SPR_WAIT : IDLE;
         SPR_WAIT: if (spr_ack) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wr_data     <= '0;
         cpu_we      <= 1'b0;
         cpu_addr    <= '0;
         chr_we      <= 1'b0;
         chr_addr    <= '0;
         spr_req     <= 1'b0;
         spr_addr    <= '0;
         spr_data    <= '0;
         prom_we     <= 1'b0;
         prom_addr   <= '0;
         load_done   <= 1'b0;
         err_ovf     <= 1'b0;
         pend_valid  <= 1'b0;
         pend_waddr  <= '0;
         pend_byte   <= '0;
         dl_active_d <= 1'b0;
         dl_seen     <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         dl_active_d <= dl_active;
         cpu_we      <= 1'b0;
         chr_we      <= 1'b0;
         prom_we     <= 1'b0;
         if (spr_req && spr_ack) spr_req <= 1'b0;
         if (dl_rise) begin
            load_done  <= 1'b0;
            err_ovf    <= 1'b0;
            pend_valid <= 1'b0;
         end
         if (dl_wr && fifo_full) err_ovf <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         // Outputs are registered at pop time so the pulse is visible during the ISSUE cycle.
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (head_addr < CHR_BASE) begin
               cpu_we   <= 1'b1;
               cpu_addr <= head_addr[15:0];
               wr_data  <= head_data;
            end else if (head_addr < SPR_BASE) begin
               chr_we   <= 1'b1;
               chr_addr <= 14'(head_addr - CHR_BASE);
               wr_data  <= head_data;
            end else if (head_addr < PROM_BASE) begin
               if (!spr_off[0]) begin
                  pend_valid <= 1'b1;
                  pend_waddr <= spr_off[14:1];
                  pend_byte  <= head_data;
               end else begin
                  spr_req    <= 1'b1;
                  spr_addr   <= spr_off[14:1];
                  spr_data   <= {head_data, spr_low};
                  pend_valid <= 1'b0;
               end
            end else if (head_addr < ROM_END) begin
               prom_we   <= 1'b1;
               prom_addr <= 10'(head_addr - PROM_BASE);
               wr_data   <= head_data;
            end
         end
         // Hold counter runs only across quiet cycles after a download; any activity restarts it.
         if (dl_active) dl_seen <= 1'b1;
         if (!dl_seen || busy) begin
            hold_cnt <= '0;
         end else if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            hold_cnt  <= '0;
            dl_seen   <= 1'b0;
            load_done <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_gb_rom_loader.sv
// tb/tb_gb_rom_loader.sv - self-checking bench for gb_rom_loader
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_gb_rom_loader;
   logic        clk_sys = 1'b0;
   logic        reset, dl_active, dl_wr, spr_ack;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [7:0]  wr_data;
   logic        cpu_we, chr_we, spr_req, prom_we, core_reset, load_done, err_ovf;
   logic [15:0] cpu_addr, spr_data;
   logic [13:0] chr_addr, spr_addr;
   logic [9:0]  prom_addr;

   gb_rom_loader dut (
      .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data), .wr_data(wr_data),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .chr_we(chr_we), .chr_addr(chr_addr),
      .spr_req(spr_req), .spr_ack(spr_ack), .spr_addr(spr_addr), .spr_data(spr_data),
      .prom_we(prom_we), .prom_addr(prom_addr), .core_reset(core_reset),
      .load_done(load_done), .err_ovf(err_ovf)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cpu_pulses = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [32:0] mq[$];
   logic [7:0]  m_wr_data;
   logic [15:0] m_cpu_addr, m_spr_data;
   logic [13:0] m_chr_addr, m_spr_addr;
   logic [9:0]  m_prom_addr;
   bit m_cpu_we, m_chr_we, m_prom_we, m_spr_req, m_load_done, m_err;
   bit m_popped, pend_v, seen, prev_act;
   int pend_w, pend_b, quiet;

   task automatic model_step();
      int sz0, a, d, o;
      bit can_pop, busy, popped_n;
      logic [32:0] it;
      if (reset) begin
         mq.delete();
         m_wr_data = 0; m_cpu_addr = 0; m_spr_data = 0; m_chr_addr = 0;
         m_spr_addr = 0; m_prom_addr = 0;
         m_cpu_we = 0; m_chr_we = 0; m_prom_we = 0; m_spr_req = 0;
         m_load_done = 0; m_err = 0; m_popped = 0; pend_v = 0;
         seen = 0; prev_act = 0; quiet = 0;
      end else begin
         sz0      = mq.size();
         can_pop  = !m_popped && !m_spr_req;
         busy     = dl_active || sz0 != 0 || m_popped || m_spr_req;
         popped_n = 0;
         m_cpu_we = 0; m_chr_we = 0; m_prom_we = 0;
         if (m_spr_req && spr_ack) m_spr_req = 0;
         if (dl_active && !prev_act) begin m_load_done = 0; m_err = 0; pend_v = 0; end
         if (can_pop && sz0 > 0) begin
            it = mq.pop_front();
            popped_n = 1;
            a = int'(it[32:8]);
            d = int'(it[7:0]);
            if (a < 'hC000) begin
               m_cpu_we = 1; m_cpu_addr = 16'(a); m_wr_data = 8'(d);
            end else if (a < 'h10000) begin
               m_chr_we = 1; m_chr_addr = 14'(a - 'hC000); m_wr_data = 8'(d);
            end else if (a < 'h18000) begin
               o = a - 'h10000;
               if (o % 2 == 0) begin
                  pend_v = 1; pend_w = o / 2; pend_b = d;
               end else begin
                  m_spr_data = {8'(d), (pend_v && pend_w == o / 2) ? 8'(pend_b) : 8'h00};
                  m_spr_addr = 14'(o / 2);
                  m_spr_req  = 1;
                  pend_v     = 0;
               end
            end else if (a < 'h18220) begin
               m_prom_we = 1; m_prom_addr = 10'(a - 'h18000); m_wr_data = 8'(d);
            end
         end
         if (dl_wr) begin
            if (sz0 == 4) m_err = 1;
            else          mq.push_back({dl_addr, dl_data});
         end
         if (dl_active) begin
            seen = 1; quiet = 0;
         end else if (seen) begin
            if (busy) quiet = 0;
            else begin
               quiet++;
               if (quiet == 16) begin m_load_done = 1; seen = 0; quiet = 0; end
            end
         end
         m_popped = popped_n;
         prev_act = dl_active;
      end
   endtask

   initial forever begin
      @(posedge clk_sys);
      model_step();
   end

   initial forever begin
      @(negedge clk_sys);
      if (cpu_we) n_cpu_pulses++;
      if (chk_en) begin
         check("m_cpu_we",    cpu_we,    m_cpu_we);
         check("m_chr_we",    chr_we,    m_chr_we);
         check("m_prom_we",   prom_we,   m_prom_we);
         check("m_spr_req",   spr_req,   m_spr_req);
         check("m_wr_data",   wr_data,   m_wr_data);
         check("m_cpu_addr",  cpu_addr,  m_cpu_addr);
         check("m_chr_addr",  chr_addr,  m_chr_addr);
         check("m_prom_addr", prom_addr, m_prom_addr);
         check("m_spr_addr",  spr_addr,  m_spr_addr);
         check("m_spr_data",  spr_data,  m_spr_data);
         check("m_load_done", load_done, m_load_done);
         check("m_err_ovf",   err_ovf,   m_err);
         check("m_core_reset", core_reset,
               reset || dl_active || mq.size() != 0 || m_popped || m_spr_req || seen);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      @(posedge clk_sys); #1;
      dl_wr = 1'b1; dl_addr = a; dl_data = d;
      @(posedge clk_sys); #1;
      dl_wr = 1'b0;
   endtask

   function automatic logic [24:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return 25'($urandom_range(0, 'hBFFF));
         1:       return 25'h0C000 + 25'($urandom_range(0, 'h3FFF));
         2, 3:    return 25'h10000 + 25'($urandom_range(0, 7)) +
                         (($urandom_range(0, 3) == 0) ? 25'h07FF8 : 25'h0);
         4:       return 25'h18000 + 25'($urandom_range(0, 'h21F));
         default: return ($urandom_range(0, 1) == 0) ? 25'h18220 + 25'($urandom_range(0, 'hFF))
                                                      : 25'h1FFFFFF;
      endcase
   endfunction

   initial begin
      int t;
      reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0; spr_ack = 1'b0;
      @(posedge clk_sys); #1; chk_en = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_cpu_we", cpu_we, 0);
      check("rst_chr_we", chr_we, 0);
      check("rst_prom_we", prom_we, 0);
      check("rst_spr_req", spr_req, 0);
      check("rst_core_reset", core_reset, 1);
      check("rst_load_done", load_done, 0);
      check("rst_err_ovf", err_ovf, 0);
      @(posedge clk_sys); #1;
      reset = 1'b0; dl_active = 1'b1;
      idle(3);

      send(25'h00123, 8'hA5); @(posedge clk_sys); @(negedge clk_sys);
      check("cpu_we", cpu_we, 1); check("cpu_addr", cpu_addr, 16'h0123); check("cpu_data", wr_data, 8'hA5);
      idle(3);
      send(25'h0C010, 8'h3C); @(posedge clk_sys); @(negedge clk_sys);
      check("chr_we", chr_we, 1); check("chr_addr", chr_addr, 14'h0010); check("chr_data", wr_data, 8'h3C);
      idle(3);
      send(25'h18005, 8'h5A); @(posedge clk_sys); @(negedge clk_sys);
      check("prom_we", prom_we, 1); check("prom_addr", prom_addr, 10'h005);
      idle(3);

      send(25'h10002, 8'h34); idle(2);
      send(25'h10003, 8'h12); @(posedge clk_sys);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         check("spr_stall_req", spr_req, 1);
         check("spr_stall_addr", spr_addr, 14'h0001);
         check("spr_stall_data", spr_data, 16'h1234);
      end
      @(posedge clk_sys); #1; spr_ack = 1'b1;
      @(negedge clk_sys); check("spr_req_at_ack", spr_req, 1);
      @(posedge clk_sys); #1; spr_ack = 1'b0;
      @(negedge clk_sys); check("spr_req_after_ack", spr_req, 0);
      idle(2);

      send(25'h10005, 8'h77); @(posedge clk_sys); @(negedge clk_sys);
      check("orphan_req", spr_req, 1); check("orphan_data", spr_data, 16'h7700);
      check("orphan_addr", spr_addr, 14'h0002);

      @(posedge clk_sys); #1;
      for (int i = 0; i < 6; i++) begin
         dl_wr = 1'b1; dl_addr = 25'h00200 + 25'(i); dl_data = 8'h40 + 8'(i);
         @(posedge clk_sys); #1;
      end
      dl_wr = 1'b0;
      @(negedge clk_sys); check("ovf_flag", err_ovf, 1);
      @(posedge clk_sys); #1; n_cpu_pulses = 0; spr_ack = 1'b1;
      @(posedge clk_sys); #1; spr_ack = 1'b0;
      idle(12);
      check("ovf_drained", n_cpu_pulses, 4);
      check("ovf_last_addr", cpu_addr, 16'h0203);
      check("ovf_last_data", wr_data, 8'h43);

      @(posedge clk_sys); #1; dl_active = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_sys);
         check("hold_core_reset", core_reset, 1);
         check("hold_load_done", load_done, 0);
      end
      @(negedge clk_sys);
      check("hold_end_core_reset", core_reset, 0);
      check("hold_end_load_done", load_done, 1);

      @(posedge clk_sys); #1; dl_active = 1'b1;
      send(25'h00010, 8'h11); send(25'h00011, 8'h22); idle(4);
      dl_active = 1'b0; idle(5);
      dl_active = 1'b1; idle(1);
      dl_active = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_sys);
         check("rehold_core_reset", core_reset, 1);
         check("rehold_load_done", load_done, 0);
      end
      t = 0;
      while (!load_done && t < 40) begin @(posedge clk_sys); #1; t++; end
      check("rehold_done", load_done, 1);

      @(posedge clk_sys); #1; dl_active = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         reset   = (c == 1700 || c == 1701);
         dl_wr   = (c < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         dl_addr = rand_addr();
         dl_data = 8'($urandom);
         spr_ack = ($urandom_range(0, 3) == 0);
         if (c >= 2500 && c < 2530) begin dl_active = 1'b0; dl_wr = 1'b0; end
         else dl_active = 1'b1;
         @(posedge clk_sys); #1;
      end
      reset = 1'b0; dl_wr = 1'b0; spr_ack = 1'b1; dl_active = 1'b0;
      t = 0;
      while (!load_done && t < 200) begin @(posedge clk_sys); #1; t++; end
      check("final_load_done", load_done, 1);
      check("final_core_reset", core_reset, 0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gb_rom_loader.md
Name: gb_rom_loader

Overview:
- Sequences the HPS ROM download stream (ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout) into the Green Beret core's ROM regions: CPU program, character, sprite and colour PROM.
- Decodes each byte into a region, buffers bytes in a small FIFO, and packs sprite bytes into 16-bit words for a stallable sprite-ROM sink.
- Holds the game core in reset until the load has fully drained.
- Sits in clk_sys between hps_io and FPGA_GreenBeret. It replaces the direct ROMCL/ROMAD/ROMDT/ROMEN hookup.

Parameters:
- CHR_BASE, 25'h0C000, first byte of character region; the CPU region is 0..CHR_BASE-1.
- SPR_BASE, 25'h10000, first byte of sprite region.
- PROM_BASE, 25'h18000, first byte of PROM region.
- ROM_END, 25'h18220, first address past PROM region; bytes at or above it are discarded.
- FIFO_DEPTH, 4, byte-entry FIFO depth (power of 2).
- HOLD_CYC, 16, clk_sys cycles that core_reset stays high after the load drains.

Ports:
- clk_sys, in, 1, system clock (48 MHz).
- reset, in, 1, synchronous active-high reset.
- dl_active, in, 1, download in progress (ioctl_download).
- dl_wr, in, 1, byte strobe, one cycle per byte.
- dl_addr, in, 25, byte address.
- dl_data, in, 8, byte data.
- wr_data, out, 8, shared data for the 8-bit regions.
- cpu_we, out, 1, CPU ROM write pulse.
- cpu_addr, out, 16, CPU byte address.
- chr_we, out, 1, character ROM write pulse.
- chr_addr, out, 14, character byte offset.
- spr_req, out, 1, sprite word write request.
- spr_ack, in, 1, sprite sink accepts the word.
- spr_addr, out, 14, sprite word offset.
- spr_data, out, 16, sprite word {odd byte, even byte}.
- prom_we, out, 1, PROM write pulse.
- prom_addr, out, 10, PROM byte offset.
- core_reset, out, 1, reset to the game core.
- load_done, out, 1, sticky flag: load completed.
- err_ovf, out, 1, sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Clock/reset: single clock clk_sys; reset synchronous active-high.
- Reset values: every output 0 except core_reset=1. Reset also empties the FIFO, puts the FSM in IDLE, clears the pending sprite byte, and clears the hold counter.
- Reset mid-download: the partial load is abandoned; nothing resumes.
- dl_active rising edge: clears load_done, err_ovf and the pending sprite byte.
- Capture: a byte is pushed on every cycle with dl_wr=1, sampled as {dl_addr, dl_data}.
  - If the FIFO is full: the byte is dropped and err_ovf is set to 1.
  - A push and a pop in the same cycle are both legal.
  - When full, a pop in the same cycle as dl_wr does NOT free a slot for that byte; it is dropped.
- FSM states: IDLE, ISSUE, SPR_WAIT.
- IDLE: if the FIFO is non-empty, pop the head into a register and go to ISSUE.
- ISSUE: performs exactly one action, then returns to IDLE (or goes to SPR_WAIT).
  - CPU (addr < CHR_BASE): cpu_we=1 for one cycle; cpu_addr = addr[15:0]; wr_data = byte.
  - CHR (CHR_BASE <= addr < SPR_BASE): chr_we=1 for one cycle; chr_addr = (addr - CHR_BASE)[13:0].
  - PROM (PROM_BASE <= addr < ROM_END): prom_we=1 for one cycle; prom_addr = (addr - PROM_BASE)[9:0].
  - SPR, even offset o = addr - SPR_BASE: latch the byte as pending, with word address o[14:1]. A new even byte overwrites any existing pending byte. No output.
  - SPR, odd offset: spr_data = {byte, pending byte}; the low byte is 8'h00 if no pending byte exists or the pending word address differs. spr_addr = o[14:1]; spr_req=1; clear pending; go to SPR_WAIT.
  - addr >= ROM_END: discard, no output.
- SPR_WAIT: spr_req, spr_addr and spr_data are held stable until the first cycle in which spr_ack=1. Then spr_req=0 on the next cycle and the FSM returns to IDLE.
  - The FIFO keeps accepting bytes during the wait.
  - spr_ack is ignored while spr_req=0.
- Latency: byte sampled at cycle N with FIFO empty and FSM in IDLE → pop at N+1 → write pulse (or spr_req) at N+2.
- Throughput: one byte per 2 cycles.
- Write pulses are exactly one cycle long and mutually exclusive. Address and data outputs hold their last value when idle.
- Reset hold: core_reset = reset OR dl_active OR FIFO non-empty OR FSM not in IDLE OR hold counter nonzero.
  - The hold counter loads HOLD_CYC on the first cycle in which dl_active=0, the FIFO is empty, the FSM is in IDLE, and a download has occurred since the last reset or load_done.
  - It then decrements once per cycle.
  - On the cycle it reaches 0, core_reset drops and load_done becomes 1 (sticky).
  - If dl_active re-asserts during the hold, the counter clears and the sequence restarts.
- A pending even sprite byte left at the end of the load is discarded; it is never written.

Test Plan:
- Reset check: assert reset for 3 cycles → all we/req outputs are 0, core_reset=1, load_done=0, err_ovf=0.
- CPU/CHR/PROM routing, with FIFO empty and FSM in IDLE for each byte:
  - dl_wr @N with addr 25'h00123, data 8'hA5 → cpu_we=1 @N+2, cpu_addr=16'h0123, wr_data=8'hA5.
  - addr 25'h0C010 → chr_we=1, chr_addr=14'h0010.
  - addr 25'h18005 → prom_we=1, prom_addr=10'h005.
- Sprite packing with stall: bytes 8'h34 @25'h10002 then 8'h12 @25'h10003; hold spr_ack=0 for 5 cycles → spr_req is held high with spr_addr=14'h0001 and spr_data=16'h1234 throughout; after spr_ack=1, spr_req drops on the next cycle.
- Orphan odd byte: 8'h77 @25'h10005 with no pending byte → spr_data=16'h7700, spr_addr=14'h0002.
- Overflow: hold spr_ack=0 and push 6 bytes back-to-back → the first 4 bytes after the stalled word are queued, later ones are dropped, and err_ovf=1.
- Hold sequence: drop dl_active with the FIFO empty → core_reset stays 1 for exactly HOLD_CYC=16 cycles, then core_reset=0 and load_done=1 in the same cycle. Re-raise dl_active mid-hold → core_reset stays 1 and load_done stays 0.
